// File: rtl/fifo_chk_pkg.sv
// Shared constants for the FIFO sequence checker: state encoding and LFSR setup.
package fifo_chk_pkg;

   typedef logic [1:0] state_t;

   localparam state_t S_IDLE = 2'd0;
   localparam state_t S_RUN  = 2'd1;
   localparam state_t S_DONE = 2'd2;

   // Fibonacci taps 16,14,13,11 mapped onto bits 15,13,12,10
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/fifo_seq_checker_if.sv
// Read-side FWFT FIFO handshake: the FIFO (master) presents empty/data, the checker (slave) pops.
interface fifo_seq_checker_if #(
   parameter int unsigned WIDTH = 32
);
   logic             FIFO_EMP;
   logic [WIDTH-1:0] FIFO_DOT;
   logic             FIFO_DEQ;

   modport master (output FIFO_EMP, output FIFO_DOT, input FIFO_DEQ);
   modport slave  (input FIFO_EMP, input FIFO_DOT, output FIFO_DEQ);
endinterface

// File: rtl/fifo_seq_checker_lfsr.sv
// 16-bit Fibonacci LFSR used to throttle reads; only built when
// FIFO_SEQ_CHECKER_THROTTLE_EN is defined.
`ifdef FIFO_SEQ_CHECKER_THROTTLE_EN
module chk_lfsr
   import fifo_chk_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic        i_en,
   output logic [15:0] o_lfsr
);

   logic [15:0] r_lfsr;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_lfsr <= LFSR_SEED;
      end else if (i_en) begin
         r_lfsr <= lfsr_next(r_lfsr);
      end
   end

   assign o_lfsr = r_lfsr;

endmodule
`endif

// File: rtl/fifo_seq_checker.sv
// Pops an FWFT FIFO and checks the data against an incrementing sequence.
// Optional read throttling under FIFO_SEQ_CHECKER_THROTTLE_EN.
//
//   state  | meaning
//   IDLE   | after reset, waiting for EN
//   RUN    | popping and checking whenever data is present
//   DONE   | NUM_WORDS checked; no further pops until reset
module fifo_seq_checker
   import fifo_chk_pkg::*;
#(
   parameter int unsigned      WIDTH     = 32,
   parameter int unsigned      NUM_WORDS = 1024,
   parameter logic [WIDTH-1:0] START_VAL = {{(WIDTH-1){1'b0}}, 1'b1},
   parameter int unsigned      ERR_W     = 16
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                EN,
   fifo_seq_checker_if.slave   fifo,
   output logic [31:0]         CHK_CNT,
   output logic [ERR_W-1:0]    ERR_CNT,
   output logic                ERR,
   output logic [WIDTH-1:0]    FIRST_ERR_DATA,
   output logic [WIDTH-1:0]    FIRST_ERR_EXP,
   output logic                DONE
);

   localparam logic [31:0] NUM_W = 32'(NUM_WORDS);

   state_t            r_state;
   logic [WIDTH-1:0]  r_exp;
   logic [31:0]       r_chk_cnt;
   logic [ERR_W-1:0]  r_err_cnt;
   logic              r_err;
   logic [WIDTH-1:0]  r_first_data;
   logic [WIDTH-1:0]  r_first_exp;

   logic              w_go;
   logic              w_deq;
   logic [31:0]       w_cnt_nxt;
   logic              w_last;
   logic              w_match;

`ifdef FIFO_SEQ_CHECKER_THROTTLE_EN
   logic [15:0] w_lfsr;

   chk_lfsr u_lfsr (
      .CLK    (CLK),
      .RST    (RST),
      .i_en   (1'b1),
      .o_lfsr (w_lfsr)
   );

   assign w_go = (w_lfsr[1:0] != 2'b00);
`else
   assign w_go = 1'b1;
`endif

   assign w_deq     = (r_state == S_RUN) & EN & ~fifo.FIFO_EMP & w_go;
   assign w_cnt_nxt = r_chk_cnt + 32'd1;
   assign w_last    = (NUM_WORDS != 0) && (w_cnt_nxt == NUM_W);
   assign w_match   = (fifo.FIFO_DOT == r_exp);

   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_state      <= S_IDLE;
         r_exp        <= START_VAL;
         r_chk_cnt    <= '0;
         r_err_cnt    <= '0;
         r_err        <= 1'b0;
         r_first_data <= '0;
         r_first_exp  <= '0;
      end else begin
         case (r_state)
            S_IDLE:  if (EN) r_state <= S_RUN;
            S_RUN:   if (w_deq && w_last) r_state <= S_DONE;
            S_DONE:  r_state <= S_DONE;
            default: r_state <= S_IDLE;
         endcase

         if (w_deq) begin
            r_chk_cnt <= w_cnt_nxt;
            if (w_match) begin
               r_exp <= r_exp + 1'b1;
            end else begin
               if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
               if (!r_err) begin
                  r_err        <= 1'b1;
                  r_first_data <= fifo.FIFO_DOT;
                  r_first_exp  <= r_exp;
               end
               // resync so a dropped/duplicated word costs one error, not a cascade
               r_exp <= fifo.FIFO_DOT + 1'b1;
            end
         end
      end
   end

   assign fifo.FIFO_DEQ  = w_deq;
   assign CHK_CNT        = r_chk_cnt;
   assign ERR_CNT        = r_err_cnt;
   assign ERR            = r_err;
   assign FIRST_ERR_DATA = r_first_data;
   assign FIRST_ERR_EXP  = r_first_exp;
   assign DONE           = (r_state == S_DONE);

endmodule

// File: doc/fifo_seq_checker.md
Name: fifo_seq_checker

Overview:
- Read-side consumer for the FIFO evaluation designs (BFIFO, DFIFO, SRL_FIFO).
- Pops words from a first-word-fall-through FIFO and checks them against the incrementing sequence the write side produces: start value, then +1 per enqueue.
- Counts words, counts mismatches, captures the first mismatch, and flags completion.
- Replaces the XOR-reduction sink in FIFO test tops, so data integrity is actually checked on hardware.

Parameters:
WIDTH, 32, data width of the FIFO under test
NUM_WORDS, 1024, words to check before DONE; 0 = run forever
START_VAL, 1, first expected word; matches the writer's reset value
ERR_W, 16, width of the error counter (saturating)

Ports:
CLK  input  1  clock
RST  input  1  synchronous, active-low reset
EN  input  1  run enable; 0 pauses popping
FIFO_EMP  input  1  FIFO empty flag
FIFO_DOT  input  WIDTH  FIFO head data, valid when FIFO_EMP=0 (FWFT)
FIFO_DEQ  output  1  pop strobe to the FIFO
CHK_CNT  output  32  number of words popped and checked
ERR_CNT  output  ERR_W  mismatch count, saturates at all-ones
ERR  output  1  sticky, set on the first mismatch
FIRST_ERR_DATA  output  WIDTH  FIFO_DOT at the first mismatch
FIRST_ERR_EXP  output  WIDTH  expected value at the first mismatch
DONE  output  1  NUM_WORDS checked

Behaviour:
- Reset (RST=0 at a CLK edge), including mid-operation:
  - state=IDLE, exp=START_VAL.
  - FIFO_DEQ=0; CHK_CNT, ERR_CNT, FIRST_ERR_* = 0; ERR=0, DONE=0.
- States: IDLE, RUN, DONE (2-bit encoding).
  - IDLE->RUN when EN=1.
  - RUN->DONE on the pop that makes CHK_CNT equal NUM_WORDS (only when NUM_WORDS!=0).
  - DONE is terminal until reset.
- FIFO_DEQ is combinational: state==RUN & EN & ~FIFO_EMP & go.
  - go=1 unless THROTTLE_EN is defined.
  - FIFO_DEQ never asserts while FIFO_EMP=1.
- Pop cycle (FIFO_DEQ=1), evaluated at the same edge:
  - CHK_CNT+1.
  - Compare FIFO_DOT against exp.
  - Match: exp<=exp+1, wrapping mod 2^WIDTH (all-ones -> 0 is not an error).
  - Mismatch:
    - ERR_CNT+1, saturating.
    - If ERR was 0: ERR<=1, FIRST_ERR_DATA<=FIFO_DOT, FIRST_ERR_EXP<=exp.
    - Resync: exp<=FIFO_DOT+1, so a dropped or duplicated word counts as one error, not a cascade.
- EN deasserted in RUN:
  - FIFO_DEQ=0 that cycle; all state held.
  - Resumes with the same exp.
- Latency: DONE and ERR are registered and rise the cycle after the deciding pop.
- DONE=1 forces FIFO_DEQ=0 even if the FIFO is non-empty.
- CHK_CNT wraps at 2^32; only relevant when NUM_WORDS=0.

Optional Feature:
- Macro FIFO_SEQ_CHECKER_THROTTLE_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 at reset) advances every cycle.
  - go = lfsr[1:0]!=2'b00, giving about 75% read duty.
  - This backs the FIFO up so full, almost-full and wrap paths are exercised.
- Not defined: go=1 and no LFSR logic is synthesised.

Decomposition:
- Shared package fifo_chk_pkg holds:
  - state encoding constants (S_IDLE=0, S_RUN=1, S_DONE=2);
  - LFSR seed and tap mask constants.
- One sub-module: chk_lfsr (16-bit LFSR, enable and reset), instantiated only under the macro.
- Compare, counters and capture stay in the top module.

Test Plan:
- Clean run: writer sends 1..1024, NUM_WORDS=1024, EN=1 → DONE rises the cycle after the 1024th pop; CHK_CNT=1024, ERR_CNT=0, ERR=0; no FIFO_DEQ after DONE.
- Dropped word: writer skips 100 (…99,101,102…) → ERR_CNT=1, FIRST_ERR_DATA=101, FIRST_ERR_EXP=100; the following words match.
- Empty/pause: hold FIFO_EMP=1 for 20 cycles, then EN=0 for 10 cycles with data present → FIFO_DEQ=0 throughout; CHK_CNT and exp unchanged; checking resumes seamlessly.
- Wrap: START_VAL=32'hFFFFFFFE, WIDTH=32, data FFFFFFFE, FFFFFFFF, 0, 1 → ERR_CNT=0, CHK_CNT=4.
- Reset mid-run: RST=0 for 1 cycle after 500 pops → next cycle all outputs 0, state IDLE, exp=START_VAL; a fresh 1..1024 stream passes cleanly.
- Throttle (macro defined): 1024 words → no errors, FIFO_DEQ duty 70-80%, DONE reached; with the macro undefined, FIFO_DEQ = ~FIFO_EMP every RUN cycle.
